// File: rtl/panel_input_ctrl.sv
// ---------------------------------------------------------------------------
// panel_input_ctrl
//
// Front-panel input block. Synchronises and debounces three push-buttons and
// turns clean presses into display-mode selection, run/halt control and
// single-step pulses for the CPU clock gating.
//
// Parameters:
//   DB_CNT     consecutive differing cycles before a new level is accepted
//   DB_W       debounce counter width
//
// Ports:
//   clk        single clock
//   rst        asynchronous active-high reset
//   btn_mode   raw button, each press advances state_show
//   btn_run    raw button, each press toggles run
//   btn_step   raw button, each press issues step_pulse while halted
//   halt_in    synchronous halt request, forces run to 0
//   state_show display selector (0 LED, 1 cycles, 2 memory, 3 branch stats)
//   run        1 = CPU free-running, 0 = halted
//   step_pulse one-cycle pulse per accepted step press
//   btn_level  debounced levels {btn_step, btn_run, btn_mode}
// ---------------------------------------------------------------------------
module panel_input_ctrl #(
   parameter int DB_CNT = 16,
   parameter int DB_W   = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_run,
   input  logic       btn_step,
   input  logic       halt_in,
   output logic [1:0] state_show,
   output logic       run,
   output logic       step_pulse,
   output logic [2:0] btn_level
);

   localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CNT - 1);
   localparam logic [DB_W-1:0] CNT_ZERO = {DB_W{1'b0}};
   localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);

   // Button index: 0 = mode, 1 = run, 2 = step
   logic [2:0]      raw;
   logic [2:0]      s1_r;
   logic [2:0]      s2_r;
   logic [2:0]      lvl_r;
   logic [2:0]      lvl_nxt_s;
   logic [2:0]      press_s;
   logic [DB_W-1:0] cnt_r     [3];
   logic [DB_W-1:0] cnt_nxt_s [3];

   logic [1:0]      show_nxt_s;
   logic            run_nxt_s;
   logic            step_nxt_s;

   assign raw = {btn_step, btn_run, btn_mode};

   // Two-flop synchroniser for all three raw buttons
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_r <= 3'b000;
         s2_r <= 3'b000;
      end else begin
         s1_r <= raw;
         s2_r <= s1_r;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_db
         // Debounce next-state: count cycles the synchronised level differs
         // from the stable level; any agreeing cycle restarts the count.
         always_comb begin
            lvl_nxt_s[gi] = lvl_r[gi];
            cnt_nxt_s[gi] = CNT_ZERO;
            if (s2_r[gi] == lvl_r[gi]) begin
               cnt_nxt_s[gi] = CNT_ZERO;
            end else if (cnt_r[gi] == CNT_LAST) begin
               lvl_nxt_s[gi] = s2_r[gi];
               cnt_nxt_s[gi] = CNT_ZERO;
            end else begin
               cnt_nxt_s[gi] = cnt_r[gi] + CNT_ONE;
            end
         end

         // Debounce counter register
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_r[gi] <= CNT_ZERO;
            end else begin
               cnt_r[gi] <= cnt_nxt_s[gi];
            end
         end
      end
   endgenerate

   // Press event: stable level is about to rise this cycle
   assign press_s = lvl_nxt_s & ~lvl_r;

   // Control next-state: mode wrap, run toggle with halt priority, step gating
   always_comb begin
      show_nxt_s = state_show;
      run_nxt_s  = run;
      step_nxt_s = 1'b0;
      if (press_s[0]) begin
         show_nxt_s = state_show + 2'd1;
      end else begin
         show_nxt_s = state_show;
      end
      // halt_in beats a coincident toggle in either direction
      if (halt_in) begin
         run_nxt_s = 1'b0;
      end else if (press_s[1]) begin
         run_nxt_s = ~run;
      end else begin
         run_nxt_s = run;
      end
      // Step accepted only against the run value in force this cycle
      if (press_s[2] && !run) begin
         step_nxt_s = 1'b1;
      end else begin
         step_nxt_s = 1'b0;
      end
   end

   // Stable levels and all registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lvl_r      <= 3'b000;
         btn_level  <= 3'b000;
         state_show <= 2'd0;
         run        <= 1'b0;
         step_pulse <= 1'b0;
      end else begin
         lvl_r      <= lvl_nxt_s;
         btn_level  <= lvl_nxt_s;
         state_show <= show_nxt_s;
         run        <= run_nxt_s;
         step_pulse <= step_nxt_s;
      end
   end

endmodule

// File: tb/tb_panel_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_panel_input_ctrl
//
// Self-checking bench for panel_input_ctrl with DB_CNT = 4. Directed tasks
// cover the listed scenarios; a randomized run is compared cycle by cycle
// against a window-based reference model: a button's level flips when the
// last DB_CNT synchronised samples all disagree with it.
// ---------------------------------------------------------------------------
module tb_panel_input_ctrl;

   localparam int DBC = 4;

   logic       clk;
   logic       rst;
   logic       btn_mode;
   logic       btn_run;
   logic       btn_step;
   logic       halt_in;
   logic [1:0] state_show;
   logic       run;
   logic       step_pulse;
   logic [2:0] btn_level;

   int pass_cnt;
   int total_cnt;

   // reference model state
   bit [2:0]  ms1;
   bit [2:0]  ms2;
   bit [2:0]  mlvl;
   bit [63:0] hist [3];
   int        hist_len [3];
   bit [1:0]  mshow;
   bit        mrun;
   bit        mstep;

   panel_input_ctrl #(.DB_CNT(DBC), .DB_W(20)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_mode  (btn_mode),
      .btn_run   (btn_run),
      .btn_step  (btn_step),
      .halt_in   (halt_in),
      .state_show(state_show),
      .run       (run),
      .step_pulse(step_pulse),
      .btn_level (btn_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      ms1 = 3'b000; ms2 = 3'b000; mlvl = 3'b000;
      for (int b = 0; b < 3; b++) begin
         hist[b] = 64'd0;
         hist_len[b] = 0;
      end
      mshow = 2'd0; mrun = 1'b0; mstep = 1'b0;
   endtask

   // one clock edge of the reference model, using pre-edge inputs
   task automatic model_edge(input bit [2:0] btn, input bit h);
      bit [2:0] press;
      bit ok;
      press = 3'b000;
      for (int b = 0; b < 3; b++) begin
         hist[b] = {hist[b][62:0], ms2[b]};
         if (hist_len[b] < 64) hist_len[b]++;
         if (hist_len[b] >= DBC) begin
            ok = 1'b1;
            for (int k = 0; k < DBC; k++)
               if (hist[b][k] == mlvl[b]) ok = 1'b0;
            if (ok) begin
               if (!mlvl[b]) press[b] = 1'b1;
               mlvl[b] = ~mlvl[b];
            end
         end
      end
      if (press[0]) mshow = mshow + 2'd1;
      mstep = press[2] && !mrun;
      if (h) mrun = 1'b0;
      else if (press[1]) mrun = ~mrun;
      ms2 = ms1;
      ms1 = btn;
   endtask

   // drive inputs, take one edge, advance the model, settle 1 time unit
   task automatic tick(input bit m, input bit r, input bit s, input bit h);
      btn_mode = m; btn_run = r; btn_step = s; halt_in = h;
      @(posedge clk);
      if (rst) model_reset();
      else model_edge({s, r, m}, h);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      btn_mode = 1'b0; btn_run = 1'b0; btn_step = 1'b0; halt_in = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if ({state_show, run, step_pulse, btn_level} !== 7'd0)
         $display("FAIL reset_outputs: got %b expected 0000000", {state_show, run, step_pulse, btn_level});
      else pass_cnt++;
      #1 rst = 1'b0;
   endtask

   task automatic test_step_latency();
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 1'b0, 1'b1, 1'b0);
         total_cnt++;
         if (step_pulse !== 1'b0) $display("FAIL step_early edge %0d: got %b expected 0", i, step_pulse);
         else pass_cnt++;
      end
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      total_cnt++;
      if (step_pulse !== 1'b1 || btn_level[2] !== 1'b1)
         $display("FAIL step_at_edge5: got pulse=%b lvl=%b expected 1 1", step_pulse, btn_level[2]);
      else pass_cnt++;
      for (int i = 0; i < 50; i++) begin
         tick(1'b0, 1'b0, 1'b1, 1'b0);
         total_cnt++;
         if (step_pulse !== 1'b0) $display("FAIL step_held cycle %0d: got %b expected 0", i, step_pulse);
         else pass_cnt++;
      end
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if (btn_level[2] !== 1'b0) $display("FAIL step_release: got %b expected 0", btn_level[2]);
      else pass_cnt++;
   endtask

   task automatic test_bounce();
      for (int rep = 0; rep < 6; rep++) begin
         for (int i = 0; i < 5; i++) begin
            tick((rep < 5) && (i < 3), 1'b0, 1'b0, 1'b0);
            total_cnt++;
            if (state_show !== 2'd0 || btn_level[0] !== 1'b0)
               $display("FAIL bounce rep %0d: got show=%0d lvl=%b expected 0 0", rep, state_show, btn_level[0]);
            else pass_cnt++;
         end
      end
   endtask

   task automatic press(input int which, input int hold, input int halt_at);
      for (int i = 0; i < hold; i++)
         tick(which == 0, which == 1, which == 2, i == halt_at);
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_mode_presses();
      logic [1:0] exp_show;
      for (int p = 1; p <= 4; p++) begin
         press(0, 8, -1);
         exp_show = 2'(p);
         total_cnt++;
         if (state_show !== exp_show) $display("FAIL mode_press %0d: got %0d expected %0d", p, state_show, exp_show);
         else pass_cnt++;
      end
   endtask

   task automatic test_run_step();
      press(1, 8, -1);
      total_cnt++;
      if (run !== 1'b1) $display("FAIL run_toggle_on: got %b expected 1", run);
      else pass_cnt++;
      for (int i = 0; i < 16; i++) begin
         tick(1'b0, 1'b0, i < 8, 1'b0);
         total_cnt++;
         if (step_pulse !== 1'b0) $display("FAIL step_while_running cycle %0d: got %b expected 0", i, step_pulse);
         else pass_cnt++;
      end
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      total_cnt++;
      if (run !== 1'b0) $display("FAIL halt_in_alone: got %b expected 0", run);
      else pass_cnt++;
      press(1, 8, -1);
      press(1, 8, 5);
      total_cnt++;
      if (run !== 1'b0) $display("FAIL halt_with_toggle_off: got %b expected 0", run);
      else pass_cnt++;
      press(1, 8, 5);
      total_cnt++;
      if (run !== 1'b0) $display("FAIL halt_beats_toggle_on: got %b expected 0", run);
      else pass_cnt++;
   endtask

   task automatic test_halt_step();
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, 1'b0, 1'b1, i == 5);
         if (i == 5) begin
            total_cnt++;
            if (step_pulse !== 1'b1 || run !== 1'b0)
               $display("FAIL halt_step_coincide: got pulse=%b run=%b expected 1 0", step_pulse, run);
            else pass_cnt++;
         end
         if (i == 6) begin
            total_cnt++;
            if (step_pulse !== 1'b0) $display("FAIL halt_step_one_cycle: got %b expected 0", step_pulse);
            else pass_cnt++;
         end
      end
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      press(0, 8, -1);
      press(0, 8, -1);
      total_cnt++;
      if (state_show !== 2'd2) $display("FAIL pre_reset_show: got %0d expected 2", state_show);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      model_reset();
      #1;
      total_cnt++;
      if ({state_show, run, step_pulse, btn_level} !== 7'd0)
         $display("FAIL mid_reset_outputs: got %b expected 0000000", {state_show, run, step_pulse, btn_level});
      else pass_cnt++;
      @(posedge clk);
      #2 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(1'b1, 1'b0, 1'b0, 1'b0);
         if (i == 4) begin
            total_cnt++;
            if (state_show !== 2'd0) $display("FAIL redebounce_early: got %0d expected 0", state_show);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (state_show !== 2'd1 || btn_level[0] !== 1'b1)
         $display("FAIL redebounce_event: got show=%0d lvl=%b expected 1 1", state_show, btn_level[0]);
      else pass_cnt++;
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      int  left [3];
      bit  val  [3];
      bit  h;
      bit [6:0] exp_v;
      for (int b = 0; b < 3; b++) begin
         left[b] = 0;
         val[b] = 1'b0;
      end
      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < 3; b++) begin
            if (left[b] == 0) begin
               val[b] = 1'($urandom_range(0, 1));
               left[b] = int'($urandom_range(1, 10));
            end
            left[b]--;
         end
         h = ($urandom_range(0, 19) == 0);
         tick(val[0], val[1], val[2], h);
         exp_v = {mshow, mrun, mstep, mlvl};
         total_cnt++;
         if ({state_show, run, step_pulse, btn_level} !== exp_v)
            $display("FAIL random cycle %0d: got %b expected %b", c, {state_show, run, step_pulse, btn_level}, exp_v);
         else pass_cnt++;
      end
   endtask

   initial begin
      pass_cnt = 0;
      total_cnt = 0;
      test_reset();
      test_step_latency();
      test_bounce();
      test_mode_presses();
      test_run_step();
      test_halt_step();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/panel_input_ctrl.md
# panel_input_ctrl

Front-panel input block for the FPGA CPU board: synchronises and debounces three push-buttons and turns clean presses into display-mode selection, run/halt control and single-step pulses. It drives the two-bit `state_show` selector consumed by the seven-segment display multiplexer, and the `run`/`step_pulse` controls consumed by the CPU clock gating. It is the input-side counterpart to the display output path.

## Interface
- `DB_CNT`, default 16: consecutive cycles a synchronised button level must differ from the stable level before it is accepted; legal range 2 … 2^`DB_W`−1.
- `DB_W`, default 20: debounce counter width.
- `clk` input 1: single clock for the whole block.
- `rst` input 1: reset, asynchronous, active-high.
- `btn_mode` input 1: raw button; each press advances `state_show`.
- `btn_run` input 1: raw button; each press toggles `run`.
- `btn_step` input 1: raw button; each press issues one `step_pulse` while halted.
- `halt_in` input 1: synchronous, from the CPU halt/syscall logic; a high cycle forces `run` to 0.
- `state_show` output 2: display selector, 0 = LED data, 1 = cycle count, 2 = memory data, 3 = branch statistics.
- `run` output 1: 1 = CPU free-running, 0 = halted.
- `step_pulse` output 1: one-cycle pulse, one per accepted step press.
- `btn_level` output 3: debounced levels {`btn_step`, `btn_run`, `btn_mode`}.

## Operation
- Per button: two-flop synchroniser (`s1`, `s2`), stable level `lvl`, counter `cnt[DB_W-1:0]`.
- Each cycle: if `s2 == lvl`, `cnt` ← 0; else if `cnt == DB_CNT-1`, `lvl` ← `s2` and `cnt` ← 0; else `cnt` ← `cnt+1`.
- A press event is asserted in the same cycle `lvl` is updated from 0 to 1. A release (1→0) is debounced identically but generates no event.
- Mode event: `state_show` ← `state_show+1`, wrapping 3→0.
- Run event: `run` ← ~`run`. If `halt_in` is high in the same cycle, `run` ← 0 (halt wins over a toggle in either direction). `halt_in` while already halted: no effect.
- Step event: `step_pulse` ← 1 for exactly one cycle only if `run` == 0 in that cycle; ignored while running. No queuing of ignored events.
- Events from different buttons in the same cycle are each processed independently.
- A bounce shorter than `DB_CNT` cycles resets `cnt` and produces no change.
- All outputs are registered; no combinational path from any input to any output.

## Timing
- Reset (async assert, sync release): `s1`, `s2`, `lvl`, `cnt` = 0 for all buttons; `state_show` = 0, `run` = 0, `step_pulse` = 0, `btn_level` = 0.
- Reset asserted mid-debounce discards the partial count; a button still held at release is re-debounced from zero and then generates a fresh press event.
- Latency: raw input high before edge 0 → `s2` high after edge 1 → `lvl`/`btn_level` and the event-driven output update at edge `DB_CNT+1`. `step_pulse` is high from edge `DB_CNT+1` to edge `DB_CNT+2`.
- `halt_in` → `run` low after one edge.
- A held button yields exactly one event; the next event requires a debounced release (`DB_CNT` cycles low) followed by a debounced press.
- Counter never exceeds `DB_CNT-1`, so there is no wrap-around.

## Test plan
- `DB_CNT`=4, halted: hold `btn_step` high from edge 0 → `step_pulse`=1 for one cycle after edge 5, `btn_level[2]`=1; held for 50 more cycles → no further pulse.
- Bounce: `btn_mode` toggled high 3 cycles / low 2 cycles, repeated 5 times, then low → `state_show` stays 0, `btn_level[0]` stays 0.
- Four clean `btn_mode` presses with releases → `state_show` steps 1, 2, 3, 0.
- `btn_run` press → `run`=1; `btn_step` press while running → no `step_pulse`; `halt_in` pulsed in the same cycle as a second run event → `run`=0.
- `run`=0, `halt_in` pulsed coincident with an accepted step event → `run` stays 0 and `step_pulse`=1 for one cycle.
- `rst` asserted with `btn_mode` 2 cycles into debounce and `state_show`=2 → all outputs 0 immediately; button still held after release → `state_show`=1 at edge `DB_CNT+1` after reset release.
